// File: rtl/qam16_symbol_slicer.sv
// qam16_symbol_slicer
//   Baseband QAM16 receive slicer feeding the 4-bit-to-32-bit symbol collector.
//   An energetic sample starts a frame search. OSR accepted samples are then
//   integrated per symbol and dumped. PREAMBLE_LEN dumps with both rails
//   positive qualify a frame. The next FRAME_WORDS*8 dumps are sliced to
//   Gray-coded I/Q bit pairs.
//
//   Build option: define QAM16_AGC_EN to derive the decision threshold from
//   the preamble energy. Without it, the threshold is the THRESH constant.
//
// Ports
//   CLK            clock
//   RST            asynchronous reset, active low
//   valid_i        sample strobe; i_i/q_i are used only when high
//   i_i, q_i       signed I/Q samples, IQ_W bits
//   valid_o        one-cycle strobe, data_o carries a new symbol
//   data_o         {Q bits[3:2], I bits[1:0]}, Gray coded, held between strobes
//   frame_start_o  one-cycle pulse when the preamble is accepted
//   busy_o         high while a frame search or frame is in progress
//
// state  | meaning
// S_IDLE | waiting for a sample with enough energy
// S_PRE  | integrating preamble symbols, all must land in the (+,+) quadrant
// S_DATA | slicing data symbols until the frame is complete

module qam16_symbol_slicer #(
   parameter int IQ_W         = 12,
   parameter int OSR          = 8,
   parameter int THRESH       = 1600,
   parameter int ENERGY_MIN   = 200,
   parameter int PREAMBLE_LEN = 4,
   parameter int FRAME_WORDS  = 4
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   valid_i,
   input  logic signed [IQ_W-1:0] i_i,
   input  logic signed [IQ_W-1:0] q_i,
   output logic                   valid_o,
   output logic [3:0]             data_o,
   output logic                   frame_start_o,
   output logic                   busy_o
);

   localparam int ACC_W = IQ_W + $clog2(OSR);
   localparam int PH_W  = $clog2(OSR);
   localparam int NSYM  = FRAME_WORDS * 8;
   localparam int SC_W  = $clog2(NSYM);
   localparam int PC_W  = (PREAMBLE_LEN > 1) ? $clog2(PREAMBLE_LEN) : 1;
   localparam int E_W   = IQ_W + 2;

   localparam logic [PH_W-1:0] PH_LAST  = PH_W'(OSR - 1);
   localparam logic [SC_W-1:0] SYM_LAST = SC_W'(NSYM - 1);
   localparam logic [PC_W-1:0] PRE_LAST = PC_W'(PREAMBLE_LEN - 1);
   localparam logic [E_W-1:0]  E_MIN    = E_W'(ENERGY_MIN);

   typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA} state_t;

   state_t                  state, state_nxt;
   logic [PH_W-1:0]         phase;
   logic [PC_W-1:0]         pre_cnt;
   logic [SC_W-1:0]         sym_cnt;
   logic signed [ACC_W-1:0] acc_i, acc_q;
   logic signed [ACC_W-1:0] ext_i, ext_q;
   logic signed [ACC_W-1:0] sum_i, sum_q;
   logic signed [ACC_W-1:0] thresh;

   logic signed [IQ_W:0]    i_x, q_x;
   logic [IQ_W:0]           abs_i, abs_q;
   logic [E_W-1:0]          energy;

   logic                    accept, trigger, dump;
   logic                    pre_bad, emit, fs_pulse;

   // One extra bit so that the most negative sample has a representable magnitude.
   assign i_x    = {i_i[IQ_W-1], i_i};
   assign q_x    = {q_i[IQ_W-1], q_i};
   assign abs_i  = i_x[IQ_W] ? $unsigned(-i_x) : $unsigned(i_x);
   assign abs_q  = q_x[IQ_W] ? $unsigned(-q_x) : $unsigned(q_x);
   assign energy = {1'b0, abs_i} + {1'b0, abs_q};

   assign ext_i = {{(ACC_W-IQ_W){i_i[IQ_W-1]}}, i_i};
   assign ext_q = {{(ACC_W-IQ_W){q_i[IQ_W-1]}}, q_i};

   // The phase-0 sample restarts the integral. The dump value therefore
   // includes the current (OSR-th) sample, and the next symbol's first
   // sample can arrive on the cycle right after a dump.
   assign sum_i = (phase == '0) ? ext_i : acc_i + ext_i;
   assign sum_q = (phase == '0) ? ext_q : acc_q + ext_q;

   assign trigger = valid_i && (state == S_IDLE) && (energy >= E_MIN);
   assign accept  = trigger || (valid_i && (state != S_IDLE));
   assign dump    = valid_i && (state != S_IDLE) && (phase == PH_LAST);
   assign pre_bad = sum_i[ACC_W-1] || (sum_i == '0) || sum_q[ACC_W-1] || (sum_q == '0);

   assign busy_o = (state != S_IDLE);

   function automatic logic [1:0] slice(input logic signed [ACC_W-1:0] a,
                                        input logic signed [ACC_W-1:0] t);
      logic [1:0] b;
      if (a < -t)
         b = 2'b00;
      else if (a[ACC_W-1])
         b = 2'b01;
      else if (a < t)
         b = 2'b11;
      else
         b = 2'b10;
      return b;
   endfunction

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      emit      = 1'b0;
      fs_pulse  = 1'b0;
      case (state)
         S_IDLE: begin
            if (trigger)
               state_nxt = S_PRE;
         end
         S_PRE: begin
            if (dump) begin
               if (pre_bad) begin
                  state_nxt = S_IDLE;
               end else if (pre_cnt == PRE_LAST) begin
                  state_nxt = S_DATA;
                  fs_pulse  = 1'b1;
               end
            end
         end
         S_DATA: begin
            if (dump) begin
               emit = 1'b1;
               if (sym_cnt == SYM_LAST)
                  state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         phase         <= '0;
         pre_cnt       <= '0;
         sym_cnt       <= '0;
         acc_i         <= '0;
         acc_q         <= '0;
         valid_o       <= 1'b0;
         data_o        <= 4'b0000;
         frame_start_o <= 1'b0;
      end else begin
         valid_o       <= emit;
         frame_start_o <= fs_pulse;
         if (emit)
            data_o <= {slice(sum_q, thresh), slice(sum_i, thresh)};
         if (accept) begin
            acc_i <= sum_i;
            acc_q <= sum_q;
            phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
         end
         if (state != S_PRE)
            pre_cnt <= '0;
         else if (dump)
            pre_cnt <= pre_cnt + 1'b1;
         if (state != S_DATA)
            sym_cnt <= '0;
         else if (dump)
            sym_cnt <= sym_cnt + 1'b1;
      end
   end

`ifdef QAM16_AGC_EN
   localparam int SUM_W  = ACC_W + 1 + $clog2(PREAMBLE_LEN);
   localparam int AVG_SH = $clog2(PREAMBLE_LEN) + 1;

   logic signed [SUM_W-1:0] pre_sum, pre_sum_nxt, avg;
   logic signed [ACC_W-1:0] t_calc;

   // avg is the mean per-rail preamble level. The threshold is about 0.656*avg,
   // which sits near 2/3 of the +3 level, between the inner and outer points.
   assign pre_sum_nxt = pre_sum + SUM_W'(sum_i) + SUM_W'(sum_q);
   assign avg         = pre_sum_nxt >>> AVG_SH;
   assign t_calc      = ACC_W'((avg >>> 1) + (avg >>> 3) + (avg >>> 5));

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         pre_sum <= '0;
         thresh  <= '0;
      end else begin
         if (state != S_PRE)
            pre_sum <= '0;
         else if (dump)
            pre_sum <= pre_sum_nxt;
         if (fs_pulse)
            thresh <= t_calc;
      end
   end
`else
   assign thresh = ACC_W'(THRESH);
`endif

endmodule
